// File: rtl/alu_mul_sequencer.sv
// Shift-and-add MUL/MULW sequencer that borrows the shared ALU in ADD mode.
// Ports: start handshake, word-op flag, operands, flush, done/result, ALU hooks.
module alu_mul_sequencer #(
    parameter int DATA_WIDTH    = 64,
    parameter int WORD_WIDTH    = 32,
    parameter int CONTROL_WIDTH = 4,
    parameter int CNT_WIDTH     = 7
) (
    input  logic                     clk,
    input  logic                     arstn,
    input  logic                     i_start_valid,
    output logic                     o_start_ready,
    input  logic                     i_word_op,
    input  logic [DATA_WIDTH-1:0]    i_src_1,
    input  logic [DATA_WIDTH-1:0]    i_src_2,
    input  logic                     i_flush,
    output logic                     o_done,
    output logic [DATA_WIDTH-1:0]    o_result,
    output logic                     o_alu_busy,
    output logic [CONTROL_WIDTH-1:0] o_alu_control,
    output logic [DATA_WIDTH-1:0]    o_alu_src_1,
    output logic [DATA_WIDTH-1:0]    o_alu_src_2,
    input  logic [DATA_WIDTH-1:0]    i_alu_result
);

    localparam logic [CONTROL_WIDTH-1:0] ALU_ADD = '0;
    localparam int EXT_W = DATA_WIDTH - WORD_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  word_q, word_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic                  ready;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [DATA_WIDTH-1:0] mplier_sh;
    logic [CNT_WIDTH-1:0]  last_cnt;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        word_d    = word_q;
        result_d  = result_q;
        ready     = (state_q == IDLE) && !i_flush;
        // Accumulator value after this CALC cycle, including its own update.
        acc_next  = mplier_q[0] ? i_alu_result : acc_q;
        mplier_sh = mplier_q >> 1;
        last_cnt  = word_q ? CNT_WIDTH'(WORD_WIDTH - 1)
                           : CNT_WIDTH'(DATA_WIDTH - 1);

        unique case (state_q)
            IDLE: begin
                if (i_start_valid && ready) begin
                    acc_d    = '0;
                    mcand_d  = i_src_1;
                    count_d  = '0;
                    word_d   = i_word_op;
                    mplier_d = i_word_op
                        ? {{EXT_W{1'b0}}, i_src_2[WORD_WIDTH-1:0]}
                        : i_src_2;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_sh;
                count_d  = count_q + 1'b1;
                // Stop early once no multiplier bits remain.
                if ((mplier_sh == '0) || (count_q == last_cnt)) begin
                    state_d  = DONE;
                    result_d = word_q
                        ? {{EXT_W{acc_next[WORD_WIDTH-1]}},
                           acc_next[WORD_WIDTH-1:0]}
                        : acc_next;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (i_flush) begin
            state_d  = IDLE;
            acc_d    = '0;
            mcand_d  = '0;
            mplier_d = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            word_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            word_q   <= word_d;
            result_q <= result_d;
        end
    end

    // done is decoded from the registered state, so a flush in the
    // DONE cycle cannot suppress the pulse.
    assign o_start_ready = ready;
    assign o_done        = (state_q == DONE);
    assign o_result      = result_q;
    assign o_alu_busy    = (state_q == CALC);
    assign o_alu_control = ALU_ADD;
    assign o_alu_src_1   = (state_q == CALC) ? acc_q : '0;
    assign o_alu_src_2   = (state_q == CALC) ? mcand_q : '0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomised self-checking bench for alu_mul_sequencer.
// A cycle-level product model is compared against the DUT every cycle.
module tb_alu_mul_sequencer;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        i_start_valid = 1'b0;
    logic        o_start_ready;
    logic        i_word_op = 1'b0;
    logic [63:0] i_src_1 = '0;
    logic [63:0] i_src_2 = '0;
    logic        i_flush = 1'b0;
    logic        o_done;
    logic [63:0] o_result;
    logic        o_alu_busy;
    logic [3:0]  o_alu_control;
    logic [63:0] o_alu_src_1;
    logic [63:0] o_alu_src_2;
    logic [63:0] i_alu_result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Combinational ALU in ADD mode.
    assign i_alu_result = o_alu_src_1 + o_alu_src_2;

    alu_mul_sequencer dut (
        .clk           (clk),
        .arstn         (arstn),
        .i_start_valid (i_start_valid),
        .o_start_ready (o_start_ready),
        .i_word_op     (i_word_op),
        .i_src_1       (i_src_1),
        .i_src_2       (i_src_2),
        .i_flush       (i_flush),
        .o_done        (o_done),
        .o_result      (o_result),
        .o_alu_busy    (o_alu_busy),
        .o_alu_control (o_alu_control),
        .o_alu_src_1   (o_alu_src_1),
        .o_alu_src_2   (o_alu_src_2),
        .i_alu_result  (i_alu_result)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int calc_cycles(input logic [63:0] m);
        int n = 0;
        for (int i = 0; i < 64; i++)
            if (m[i]) n = i + 1;
        return (n == 0) ? 1 : n;
    endfunction

    function automatic logic [63:0] product(input logic [63:0] a,
                                            input logic [63:0] m,
                                            input logic w);
        logic [63:0] p;
        p = a * m;
        return w ? {{32{p[31]}}, p[31:0]} : p;
    endfunction

    // Behavioural model: phase 0 idle, 1 calculating, 2 done.
    int          m_phase = 0;
    int          m_k = 0;
    int          m_calc = 1;
    logic [63:0] m_a = '0;
    logic [63:0] m_b = '0;
    logic        m_w = 1'b0;
    logic [63:0] m_res = '0;

    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            m_phase = 0;
            m_res   = '0;
        end else begin
            case (m_phase)
                0: if (i_start_valid && !i_flush) begin
                    m_a     = i_src_1;
                    m_w     = i_word_op;
                    m_b     = i_word_op ? {32'b0, i_src_2[31:0]} : i_src_2;
                    m_k     = 0;
                    m_calc  = calc_cycles(m_b);
                    m_phase = 1;
                end
                1: if (i_flush) begin
                    m_phase = 0;
                end else begin
                    m_k++;
                    if (m_k == m_calc) begin
                        m_phase = 2;
                        m_res   = product(m_a, m_b, m_w);
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic [63:0] mask;
        logic [63:0] part;
        if (arstn) begin
            mask = (64'd1 << m_k) - 64'd1;
            part = m_a * (m_b & mask);
            check("ready", 64'(o_start_ready),
                  64'((m_phase == 0) && !i_flush));
            check("busy", 64'(o_alu_busy), 64'(m_phase == 1));
            check("done", 64'(o_done), 64'(m_phase == 2));
            check("result", o_result, m_res);
            check("alu_ctl", 64'(o_alu_control), 64'd0);
            check("alu_src1", o_alu_src_1, (m_phase == 1) ? part : 64'd0);
            check("alu_src2", o_alu_src_2,
                  (m_phase == 1) ? (m_a << m_k) : 64'd0);
        end
    end

    task automatic start(input logic [63:0] a, input logic [63:0] b,
                         input logic w);
        bit ok = 0;
        i_start_valid = 1'b1;
        i_src_1       = a;
        i_src_2       = b;
        i_word_op     = w;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = o_start_ready;
            @(posedge clk);
        end
        #1;
        i_start_valid = 1'b0;
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input string name, input logic [63:0] a,
                          input logic [63:0] b, input logic w,
                          input bit pin, input logic [63:0] exp_res,
                          input int exp_lat);
        int lat = 0;
        start(a, b, w);
        for (int i = 1; i <= 200 && lat == 0; i++) begin
            @(negedge clk);
            if (o_done) lat = i;
        end
        if (lat == 0) check({name, "_done_timeout"}, 64'd0, 64'd1);
        if (pin) begin
            check({name, "_lat"}, 64'(lat), 64'(exp_lat));
            check({name, "_res"}, o_result, exp_res);
        end
        @(negedge clk);
        check({name, "_ready_after"}, 64'(o_start_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        #2;
        check("rst_busy", 64'(o_alu_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_result", o_result, 64'd0);
        check("rst_src1", o_alu_src_1, 64'd0);
        repeat (2) @(posedge clk);
        #1 arstn = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul3x5", 64'd3, 64'd5, 1'b0, 1, 64'd15, 4);
        run_op("mulx0", 64'h1234, 64'd0, 1'b0, 1, 64'd0, 2);
        run_op("mulff", '1, '1, 1'b0, 1, 64'd1, 65);
        run_op("mulw2", 64'h7FFF_FFFF, 64'hFFFF_FFFF_0000_0002, 1'b1, 1,
               64'hFFFF_FFFF_FFFF_FFFE, 3);
        run_op("mulwm1", '1, '1, 1'b1, 1, 64'd1, 33);

        // Flush on the 4th CALC cycle.
        start(64'd7, 64'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #1 i_flush = 1'b1;
        @(posedge clk);
        #1 i_flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("flush_no_done", 64'(o_done), 64'd0);
        end
        check("flush_held", o_result, 64'd1);
        run_op("mul2x3", 64'd2, 64'd3, 1'b0, 1, 64'd6, 3);

        // Flush together with start is not accepted.
        @(posedge clk);
        #1;
        i_flush = 1'b1;
        i_start_valid = 1'b1;
        i_src_1 = 64'd5;
        i_src_2 = 64'd5;
        @(negedge clk);
        check("flush_start_ready", 64'(o_start_ready), 64'd0);
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        i_start_valid = 1'b0;
        @(negedge clk);
        check("flush_start_busy", 64'(o_alu_busy), 64'd0);

        // Reset mid-operation.
        @(posedge clk);
        #1;
        start(64'd9, 64'd9, 1'b0);
        @(posedge clk);
        #1 arstn = 1'b0;
        #1;
        check("arst_busy", 64'(o_alu_busy), 64'd0);
        check("arst_done", 64'(o_done), 64'd0);
        check("arst_result", o_result, 64'd0);
        check("arst_ready", 64'(o_start_ready), 64'd1);
        @(posedge clk);
        #1 arstn = 1'b1;
        run_op("post_rst", 64'd9, 64'd9, 1'b0, 1, 64'd81, 5);

        for (int t = 0; t < 40; t++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (t % 3 == 0) b = b >> $urandom_range(63, 40);
            run_op("rand", a, b, 1'($urandom_range(1, 0)), 0, '0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
